comparator_sched: RTL

COMPARATOR_SCHED -- requirements
Module: comparator_sched

---
 rtl/comparator_sched_pkg.sv | 39 +++
 rtl/comparator_sched_rr_arbiter.sv | 42 ++++
 rtl/comparator_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/comparator_sched_pkg.sv
// Shared types and constants for the comparator scheduler.
// COMPARATOR_SCHED_EXTRA_EVAL_EN adds a second evaluate state (EVAL2).
package comparator_sched_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 16;

  localparam logic PRECHARGE = 1'b0;
  localparam logic EVALUATE  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_EVAL  = 3'd2,
`ifdef COMPARATOR_SCHED_EXTRA_EVAL_EN
    ST_EVAL2 = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

`ifdef COMPARATOR_SCHED_EXTRA_EVAL_EN
  localparam state_t LAST_EVAL = ST_EVAL2;
`else
  localparam state_t LAST_EVAL = ST_EVAL;
`endif

  function automatic logic phase_of(input state_t s);
    logic ph;
    case (s)
      ST_EVAL:  ph = EVALUATE;
`ifdef COMPARATOR_SCHED_EXTRA_EVAL_EN
      ST_EVAL2: ph = EVALUATE;
`endif
      default:  ph = PRECHARGE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/comparator_sched_rr_arbiter.sv
// Combinational round-robin picker: first active request after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import comparator_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   grant
);

  int               sum_s;
  logic [IDX_W-1:0] cand_s;

  // Scan offsets 1..NUM_REQ so last_grant itself is checked last.
  always_comb begin
    valid  = 1'b0;
    grant  = '0;
    sum_s  = '0;
    cand_s = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum_s = int'(last_grant) + off;
      if (sum_s >= NUM_REQ) begin
        sum_s = sum_s - NUM_REQ;
      end else begin
        sum_s = sum_s;
      end
      cand_s = IDX_W'(sum_s);
      if (!valid && req[cand_s]) begin
        valid = 1'b1;
        grant = cand_s;
      end else begin
        valid = valid;
        grant = grant;
      end
    end
  end

endmodule

// File: rtl/comparator_sched.sv
// Time-shares one precharge/evaluate comparator among NUM_REQ requesters.
// Define COMPARATOR_SCHED_EXTRA_EVAL_EN to stretch evaluation to two cycles.
module comparator_sched
  import comparator_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       done,
  output logic                     result,
  output logic                     busy,
  output logic                     cmp_clk,
  output logic [WIDTH-1:0]         cmp_a,
  output logic [WIDTH-1:0]         cmp_b,
  input  logic                     cmp_result
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_r;
  state_t             state_s;
  logic [IDX_W-1:0]   last_grant_r;
  logic [IDX_W-1:0]   winner_r;
  logic               arb_valid_s;
  logic [IDX_W-1:0]   arb_grant_s;
  logic               accept_s;
  logic               sample_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [NUM_REQ-1:0] done_s;

  logic [NUM_REQ-1:0] done_r;
  logic               result_r;
  logic               busy_r;
  logic               cmp_clk_r;
  logic [WIDTH-1:0]   cmp_a_r;
  logic [WIDTH-1:0]   cmp_b_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant_r),
    .valid      (arb_valid_s),
    .grant      (arb_grant_s)
  );

  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_s = ST_PRE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE:   state_s = ST_EVAL;
`ifdef COMPARATOR_SCHED_EXTRA_EVAL_EN
      ST_EVAL:  state_s = ST_EVAL2;
      ST_EVAL2: state_s = ST_DONE;
`else
      ST_EVAL:  state_s = ST_DONE;
`endif
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && arb_valid_s;
    sample_s = (state_r == LAST_EVAL);
    sel_a_s  = req_a[int'(arb_grant_s)*WIDTH +: WIDTH];
    sel_b_s  = req_b[int'(arb_grant_s)*WIDTH +: WIDTH];
    done_s   = '0;
    if (state_s == ST_DONE) begin
      done_s[winner_r] = 1'b1;
    end else begin
      done_s = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      winner_r     <= '0;
      cmp_a_r      <= '0;
      cmp_b_r      <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        last_grant_r <= arb_grant_s;
        winner_r     <= arb_grant_s;
        cmp_a_r      <= sel_a_s;
        cmp_b_r      <= sel_b_s;
      end else begin
        last_grant_r <= last_grant_r;
        winner_r     <= winner_r;
        cmp_a_r      <= cmp_a_r;
        cmp_b_r      <= cmp_b_r;
      end
    end
  end

  // Result is captured at the closing edge of the final evaluate cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_r    <= '0;
      result_r  <= 1'b0;
      busy_r    <= 1'b0;
      cmp_clk_r <= PRECHARGE;
    end else begin
      done_r    <= done_s;
      busy_r    <= (state_s != ST_IDLE);
      cmp_clk_r <= phase_of(state_s);
      if (sample_s) begin
        result_r <= cmp_result;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign done    = done_r;
  assign result  = result_r;
  assign busy    = busy_r;
  assign cmp_clk = cmp_clk_r;
  assign cmp_a   = cmp_a_r;
  assign cmp_b   = cmp_b_r;

endmodule
